// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU: single-cycle add/inverted add/subtract, shift-add multiply.
// Optional macro SEQ_ALU_EARLY_TERM_EN ends a multiply once no multiplier bits remain set.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 zero,
  output logic                 borrow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, MUL} state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   product, mplier, product_step, alu_res;
  logic [WIDTH-1:0]     mcand;
  logic [CW-1:0]        cnt;
  logic [WIDTH:0]       sum;
  logic                 mul_last;

  // Single-cycle arithmetic, widened by one bit so carries survive.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    case (op)
      2'b00:   sum = {1'b0, a} + {1'b0, b};
      2'b01:   sum = {1'b0, ~a} + {1'b0, ~b};
      default: sum = {1'b0, a - b};
    endcase
    alu_res = {{(WIDTH-1){1'b0}}, sum};
  end

  // mplier tracks a << cnt and mcand tracks b >> cnt, so each step looks only at bit 0.
  assign product_step = mcand[0] ? (product + mplier) : product;

`ifdef SEQ_ALU_EARLY_TERM_EN
  assign mul_last = (cnt == CW'(WIDTH - 1)) || (mcand[WIDTH-1:1] == '0);
`else
  assign mul_last = (cnt == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && op == 2'b11) state_nxt = MUL;
      MUL:     if (mul_last)             state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MUL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      result  <= '0;
      zero    <= 1'b0;
      borrow  <= 1'b0;
      product <= '0;
      mplier  <= '0;
      mcand   <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (op == 2'b11) begin
            mplier  <= {{WIDTH{1'b0}}, a};
            mcand   <= b;
            product <= '0;
            cnt     <= '0;
          end else begin
            result <= alu_res;
            zero   <= (alu_res == '0);
            borrow <= (op == 2'b10) && (a < b);
            done   <= 1'b1;
          end
        end
      end else begin
        product <= product_step;
        mplier  <= mplier << 1;
        mcand   <= mcand >> 1;
        cnt     <= cnt + CW'(1);
        if (mul_last) begin
          result <= product_step;
          zero   <= (product_step == '0);
          borrow <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered successor to the team's 3-bit combinational ALU (add, inverted add, subtract, multiply).
- Operand width is set by WIDTH.
- Add, inverted add and subtract complete in one clock.
- Multiply is a multi-cycle shift-add unit with a start/busy/done handshake, replacing the full-adder array.
- Serves as the arithmetic engine for datapaths that issue one operation at a time and wait for done.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
start  input  1  operation request, sampled on rising clk edge
op  input  2  00 add, 01 inverted add, 10 subtract, 11 multiply
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse: result/flags updated
result  output  2*WIDTH  registered result, zero-extended
zero  output  1  result == 0, updated with done
borrow  output  1  subtract only: a < b; 0 for other ops

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, result, zero, borrow, counter and internal operand/product registers all 0. Takes effect immediately, including mid-multiply; any in-flight operation is discarded and done is not produced.
- States: IDLE, MUL.
- IDLE, start=1, op!=11, at edge E:
  - result, zero and borrow are written at E.
  - done=1 for the cycle after E, then returns to 0.
  - State stays IDLE.
- Arithmetic rules for single-cycle ops:
  - op 00: result = a + b, computed in WIDTH+1 bits, zero-extended to 2*WIDTH.
  - op 01: result = (~a) + (~b), computed in WIDTH+1 bits, zero-extended to 2*WIDTH.
  - op 10: result[WIDTH-1:0] = (a - b) mod 2^WIDTH; upper bits 0; borrow = (a < b).
- IDLE, start=1, op=11, at edge E:
  - Capture a, b into internal registers; product=0; cnt=0; busy=1; state=MUL.
- MUL, each edge, one step of shift-add:
  - If mcand bit cnt is 1, add a << cnt into product.
  - cnt increments.
- Completion:
  - On the WIDTH-th MUL edge: result=product (full 2*WIDTH bits), zero updated, borrow=0, done=1, busy=0, state=IDLE.
  - Latency from start edge to done-high edge is exactly WIDTH edges.
- start while busy=1 is ignored; no queueing. Operand/op changes during MUL have no effect.
- start may be asserted in the cycle where done=1; state is already IDLE, so it is accepted normally.
- result, zero and borrow hold their values until the next completion; they are never cleared except by reset.
- done and busy are never high in the same cycle.
- No overflow exceptions: all widths are sized so no information is lost except the modulo behaviour of subtract.

Optional Feature:
Macro SEQ_ALU_EARLY_TERM_EN.
- Defined:
  - Multiply completes on the first MUL edge after which all remaining unprocessed multiplier bits are 0.
  - Minimum one MUL edge; b=0 completes after 1 edge with result 0.
  - Latency is 1..WIDTH edges. Result value is identical to the non-early-termination case.
- Undefined: fixed WIDTH-edge multiply latency as above.
- Single-cycle ops are unaffected either way.

Test Plan:
All scenarios use WIDTH=8.
- Reset: hold rst_n=0 for 2 cycles, then release -> busy=0, done=0, result=0, zero=0, borrow=0.
- Add: a=8'hFF, b=8'h01, op=00, start pulse -> next cycle done=1, result=16'h0100, zero=0, busy never high.
- Inverted add: a=8'h03, b=8'h07, op=01 -> result=16'h01F4.
- Subtract:
  - a=8'h03, b=8'h07, op=10 -> result=16'h00FC, borrow=1.
  - Then a=b=8'h07 -> result=0, zero=1, borrow=0.
- Multiply:
  - a=b=8'hFF, op=11 -> busy high exactly 8 cycles, done on the 8th edge, result=16'hFE01.
  - A second start pulsed at cycle 3 is ignored (no extra done).
  - Back-to-back start in the done cycle is accepted.
- Reset mid-multiply:
  - Assert rst_n=0 asynchronously at MUL cycle 4 -> busy/result clear immediately, no done.
  - Then 8'h03*8'h05 -> result=16'h000F after 8 edges.
  - With SEQ_ALU_EARLY_TERM_EN: a=8'h05, b=8'h01 -> done after 1 edge, result=16'h0005.
